// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO read and write logic.
// Gray/binary converters work on vectors up to GW bits, zero-extended.
package fifo_pkg;

    localparam int PTR_SZ_DEF = 2;
    localparam int GW = 16;

    typedef logic [GW-1:0] gvec_t;

    function automatic gvec_t bin2gray(input gvec_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits fold through harmlessly, so any width <= GW works.
    function automatic gvec_t gray2bin(input gvec_t g);
        gvec_t b;
        b[GW-1] = g[GW-1];
        for (int i = GW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Two-flop synchronizer for a Gray-coded FIFO pointer.
// Shared by the read and write sides of the dual-clock FIFO.
module fifo_ptr_sync #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_read_logic.sv
// Read-side pointer, empty flag and Gray pointer export for the async FIFO.
// Optional read-side occupancy output enabled by FIFO_RD_LEVEL_EN.
module fifo_read_logic
    import fifo_pkg::*;
#(
    parameter int PTR_SZ = PTR_SZ_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rinc,
    input  logic [PTR_SZ:0]   waddr_gray,
    output logic              rempty,
    output logic              read_en,
    output logic [PTR_SZ-1:0] raddr,
    output logic [PTR_SZ:0]   raddr_gray
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [PTR_SZ:0]   rlevel
`endif
);

    localparam int PW = PTR_SZ + 1;

    logic [PTR_SZ:0] rbin;
    logic [PTR_SZ:0] rbin_next;
    logic [PTR_SZ:0] rgray_next;
    logic [PTR_SZ:0] wq2_waddr;
    logic            rd_acc;

    fifo_ptr_sync #(
        .W (PW)
    ) u_wsync (
        .clk (clk),
        .rst (rst),
        .d   (waddr_gray),
        .q   (wq2_waddr)
    );

    always_comb begin
        rd_acc     = rinc && !rempty;
        rbin_next  = rbin + PW'(rd_acc);
        rgray_next = PW'(bin2gray(gvec_t'(rbin_next)));
    end

    // Full-pointer compare: the wrap bit separates empty from full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rbin       <= '0;
            raddr_gray <= '0;
            rempty     <= 1'b1;
        end else begin
            rbin       <= rbin_next;
            raddr_gray <= rgray_next;
            rempty     <= (rgray_next == wq2_waddr);
        end
    end

    assign raddr   = rbin[PTR_SZ-1:0];
    assign read_en = !rempty;

`ifdef FIFO_RD_LEVEL_EN
    logic [PTR_SZ:0] wbin_sync;

    always_comb begin
        wbin_sync = PW'(gray2bin(gvec_t'(wq2_waddr)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rlevel <= '0;
        end else begin
            rlevel <= wbin_sync - rbin_next;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_read_logic.sv
// Self-checking bench for fifo_read_logic (PTR_SZ=2) against a
// count-based model of the read side of an async FIFO.
module tb_fifo_read_logic;

    localparam int P   = 2;
    localparam int MOD = 8;
    localparam int DEP = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         rinc;
    logic [P:0]   waddr_gray;
    logic         rempty;
    logic         read_en;
    logic [P-1:0] raddr;
    logic [P:0]   raddr_gray;
`ifdef FIFO_RD_LEVEL_EN
    logic [P:0]   rlevel;
`endif

    int checks = 0;
    int errors = 0;

    // Model: write count as seen by the read side, read count, flags.
    int wptr;
    int w_at1, w_at2;
    int m_rptr, m_level, m_empty;

    fifo_read_logic #(
        .PTR_SZ (P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rinc       (rinc),
        .waddr_gray (waddr_gray),
        .rempty     (rempty),
        .read_en    (read_en),
        .raddr      (raddr),
        .raddr_gray (raddr_gray)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .rlevel     (rlevel)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & (MOD - 1);
    endfunction

    task automatic model_reset();
        wptr    = 0;
        w_at1   = 0;
        w_at2   = 0;
        m_rptr  = 0;
        m_level = 0;
        m_empty = 1;
    endtask

    // Reads are allowed only when the model shows data; the read side
    // sees a write pointer that is two clock edges old.
    task automatic model_edge(input bit ri);
        int seen;
        seen = w_at2;
        if (ri && m_empty == 0) m_rptr = (m_rptr + 1) % MOD;
        m_level = (seen - m_rptr + MOD) % MOD;
        m_empty = (m_level == 0) ? 1 : 0;
        w_at2 = w_at1;
        w_at1 = wptr;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".rempty"}, int'(rempty), m_empty);
        check_eq({tag, ".read_en"}, int'(read_en), 1 - m_empty);
        check_eq({tag, ".raddr"}, int'(raddr), m_rptr % DEP);
        check_eq({tag, ".raddr_gray"}, int'(raddr_gray), to_gray(m_rptr));
`ifdef FIFO_RD_LEVEL_EN
        check_eq({tag, ".rlevel"}, int'(rlevel), m_level);
`endif
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input bit ri, input int w, input string tag);
        rinc       = ri;
        wptr       = w % MOD;
        waddr_gray = 3'(to_gray(wptr));
        @(posedge clk);
        model_edge(ri);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic reset_dut();
        rst        = 1'b0;
        rinc       = 1'b0;
        waddr_gray = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [P:0] prev_g;
        int         gseq[$];
        int         aseq[$];
        int         exp_g[8] = '{1, 3, 2, 6, 7, 5, 4, 0};
        int         exp_a[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
        bit         ri;

        // Reset held with rinc active
        rst        = 1'b0;
        rinc       = 1'b1;
        waddr_gray = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst.rempty", int'(rempty), 1);
        check_eq("rst.read_en", int'(read_en), 0);
        check_eq("rst.raddr", int'(raddr), 0);
        check_eq("rst.raddr_gray", int'(raddr_gray), 0);
`ifdef FIFO_RD_LEVEL_EN
        check_eq("rst.rlevel", int'(rlevel), 0);
`endif
        rst = 1'b1;
        step(1, 0, "rel0");
        step(1, 0, "rel1");

        // Single entry: empty falls after the third edge
        step(0, 1, "one0");
        step(0, 1, "one1");
        check_eq("one.empty_e2", int'(rempty), 1);
        step(0, 1, "one2");
        check_eq("one.empty_e3", int'(rempty), 0);
        step(1, 1, "one_rd");
        check_eq("one.raddr", int'(raddr), 1);
        check_eq("one.raddr_gray", int'(raddr_gray), 1);
        check_eq("one.rempty", int'(rempty), 1);

        // Reading while empty is ignored
        reset_dut();
        for (int i = 0; i < 5; i++) step(1, 0, "emp_rd");
        check_eq("emp.raddr", int'(raddr), 0);
        check_eq("emp.raddr_gray", int'(raddr_gray), 0);
        check_eq("emp.rempty", int'(rempty), 1);

        // Wrap-around: 8 writes with continuous reads
        reset_dut();
        prev_g = '0;
        for (int k = 1; k <= 14; k++) begin
            step(1, (k > 8) ? 8 : k, "wrap");
            if (raddr_gray != prev_g) begin
                gseq.push_back(int'(raddr_gray));
                aseq.push_back(int'(raddr));
                prev_g = raddr_gray;
            end
        end
        check_eq("wrap.count", gseq.size(), 8);
        for (int i = 0; i < 8 && i < gseq.size(); i++) begin
            check_eq($sformatf("wrap.gray%0d", i), gseq[i], exp_g[i]);
            check_eq($sformatf("wrap.addr%0d", i), aseq[i], exp_a[i]);
        end
        check_eq("wrap.rempty", int'(rempty), 1);

        // Full FIFO: write pointer four ahead
        reset_dut();
        for (int i = 0; i < 3; i++) step(0, 4, "full");
        check_eq("full.rempty", int'(rempty), 0);
`ifdef FIFO_RD_LEVEL_EN
        check_eq("full.rlevel", int'(rlevel), 4);
`endif
        step(1, 4, "full_rd");
`ifdef FIFO_RD_LEVEL_EN
        check_eq("full_rd.rlevel", int'(rlevel), 3);
`endif
        check_eq("full_rd.raddr", int'(raddr), 1);

        // Asynchronous reset between edges after three reads
        reset_dut();
        for (int i = 0; i < 3; i++) step(0, 3, "mr_w");
        for (int i = 0; i < 3; i++) step(1, 3, "mr_r");
        check_eq("mr.raddr_pre", int'(raddr), 3);
        #2;
        rst = 1'b0;
        #1;
        check_eq("mr.rempty", int'(rempty), 1);
        check_eq("mr.read_en", int'(read_en), 0);
        check_eq("mr.raddr", int'(raddr), 0);
        check_eq("mr.raddr_gray", int'(raddr_gray), 0);
        check_eq("mr.sync1", int'(dut.u_wsync.meta), 0);
        check_eq("mr.sync2", int'(dut.u_wsync.q), 0);
`ifdef FIFO_RD_LEVEL_EN
        check_eq("mr.rlevel", int'(rlevel), 0);
`endif
        model_reset();
        waddr_gray = '0;
        @(negedge clk);
        rst = 1'b1;

        // Random traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_dut();
            end else begin
                ri = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1 &&
                    ((wptr - m_rptr + MOD) % MOD) < DEP) begin
                    step(ri, wptr + 1, "rand");
                end else begin
                    step(ri, wptr, "rand");
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_read_logic.md
# fifo_read_logic

Read-side pointer and status logic for the team's dual-clock FIFO. It is the read-domain counterpart of the FIFO write logic. It synchronizes the write-side Gray pointer into the read clock domain, maintains the binary and Gray read pointers, and raises `rempty`. Its `raddr_gray` output goes back to the write domain, where it is synchronized and used for full detection.

## Interface
- `PTR_SZ`, default 2: FIFO entry index size in bits. Depth is 2^PTR_SZ; pointers are PTR_SZ+1 bits. Minimum value is 2.
- `clk`  in  1  read-domain clock.
- `rst`  in  1  asynchronous, active-low reset.
- `rinc`  in  1  read request; sampled on posedge `clk`.
- `waddr_gray`  in  PTR_SZ+1  write pointer in Gray code, driven from the write domain and not yet synchronized.
- `rempty`  out  1  FIFO empty, as seen from the read domain; registered.
- `read_en`  out  1  equals `!rempty`; qualifies the memory read.
- `raddr`  out  PTR_SZ  memory read address; registered.
- `raddr_gray`  out  PTR_SZ+1  read pointer in Gray code for the write domain; registered.
- `rlevel`  out  PTR_SZ+1  occupancy seen from the read side; registered. Present only with `FIFO_RD_LEVEL_EN`.

## Operation
- Internal binary read pointer `rbin` is PTR_SZ+1 bits.
  - `raddr = rbin[PTR_SZ-1:0]`.
  - `raddr_gray` is a register holding `rbin_next ^ (rbin_next >> 1)`.
- Read acceptance: a read is accepted at a posedge when `rinc && !rempty`.
  - Accepted read: `rbin_next = rbin + 1`, wrapping modulo 2^(PTR_SZ+1).
  - Otherwise `rbin_next = rbin`.
  - `rinc` while empty is ignored: no pointer change and no error flag.
- Synchronizer: `waddr_gray` passes through a 2-flop synchronizer, giving `wq2_waddr`. Both flops reset to 0.
- Empty: `rempty` register loads `(gray(rbin_next) == wq2_waddr)`.
  - Empty is full-pointer equality, MSB included.
  - The wrap bit distinguishes empty from full.
- Reset (`rst` low, asynchronous): `rbin`, `raddr` and `raddr_gray` clear to 0, both sync flops clear to 0, `rempty` = 1, `rlevel` = 0.
- Reset may assert mid-operation. All state clears immediately; no partial read is retained.
- Simultaneous events: a last-entry read and a write-pointer change arriving in the same cycle is resolved by the equality above.
  - `rempty` may assert for a cycle and then deassert once the new `wq2_waddr` is visible.
  - This is pessimistic and acceptable.
- `rempty` never reports non-empty when the FIFO is truly empty.

## Timing
- Read pointer latency: an accepted read at edge N gives new `raddr`, `raddr_gray` and `rempty` after edge N. Back-to-back reads run at 1 per cycle.
- Write-to-empty latency: `waddr_gray` stable before edge 1 → captured by sync flop 1 at edge 1 → sync flop 2 at edge 2 → `rempty` deasserts after edge 3.
- All outputs are register-driven; there are no combinational paths from `waddr_gray` to any output.
- `raddr_gray` changes at most 1 bit per clock.

## Configuration
- Macro: `FIFO_RD_LEVEL_EN`.
- Defined: the `rlevel` port exists.
  - `rlevel` register loads `gray2bin(wq2_waddr) - rbin_next`, modulo 2^(PTR_SZ+1).
  - Range is 0 to 2^PTR_SZ; it updates in the same cycle as `rempty`.
- Undefined: the `rlevel` port, the Gray-to-binary converter and the level register are absent. All other behaviour is identical.

## Structure
- Shared package `fifo_pkg` holds:
  - `bin2gray` and `gray2bin` functions parameterized by width;
  - default `PTR_SZ`.
- The write logic uses the same package.
- One sub-module, `fifo_ptr_sync`: a PTR_SZ+1-bit, 2-flop synchronizer with async active-low reset.
  - This block uses it for `waddr_gray`.
  - The write side reuses it for `raddr_gray`.

## Test plan
All scenarios use PTR_SZ=2.
- Reset state: hold `rst` low with `rinc`=1 → `rempty`=1, `read_en`=0, `raddr`=0, `raddr_gray`=000, `rlevel`=0. Release → no change.
- Single entry: set `waddr_gray`=001 → `rempty` falls after the 3rd posedge. Pulse `rinc` for 1 cycle → `raddr`=1, `raddr_gray`=001, `rempty`=1 on the next cycle.
- Read while empty: `rinc`=1 for 5 cycles with `waddr_gray`=000 → `raddr` and `raddr_gray` stay 0, `rempty` stays 1.
- Wrap-around: step `waddr_gray` through 8 writes and read continuously. Checks:
  - `raddr_gray` follows 001, 011, 010, 110, 111, 101, 100, 000;
  - `raddr` follows 1, 2, 3, 0, 1, 2, 3, 0;
  - `rempty`=1 at the end.
- Full level (with `FIFO_RD_LEVEL_EN`): `waddr_gray`=110 (binary 4) and no reads → `rlevel`=4 after edge 3. One read → `rlevel`=3.
- Mid-operation reset: after 3 reads, pulse `rst` low between clock edges → all outputs return to reset values immediately, and the sync flops read 0.
